// File: rtl/fp_sub_sp_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (Result = A - B).
// Truncating rounding, denormals flushed to zero, start/Done handshake.
// state/nstate are exported for debug and waveform inspection.
module fp_sub_sp_seq #(
   parameter int W  = 32,
   parameter int SW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [W-1:0]  A,
   input  logic [W-1:0]  B,
   output logic [W-1:0]  Result,
   output logic          Done,
   output logic          ovf_flag,
   output logic          unf_flag,
   output logic [SW-1:0] state,
   output logic [SW-1:0] nstate
);

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_UNPACK = 4'd1,
      ST_SWAP   = 4'd2,
      ST_ALIGN  = 4'd3,
      ST_ADDSUB = 4'd4,
      ST_NORM   = 4'd5,
      ST_PACK   = 4'd6,
      ST_DONE   = 4'd7
   } state_t;

   state_t        r_state;
   state_t        w_nstate;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic          r_sx;
   logic          r_sy;
   logic [9:0]    r_ex;
   logic [9:0]    r_ey;
   logic [24:0]   r_mx;
   logic [24:0]   r_my;
   logic [W-1:0]  r_result;
   logic          r_done;
   logic          r_ovf;
   logic          r_unf;

   // Operand decode (valid while in UNPACK, r_a/r_b hold the captured operands)
   logic [7:0]    w_ea;
   logic [7:0]    w_eb;
   logic [22:0]   w_fa;
   logic [22:0]   w_fb;
   logic          w_a_inf;
   logic          w_b_inf;
   logic          w_nan;
   logic          w_special;
   logic          w_inf_sign;
   logic          w_swap;
   logic [9:0]    w_diff;
   logic [24:0]   w_sum;

   assign w_ea       = r_a[30:23];
   assign w_eb       = r_b[30:23];
   assign w_fa       = r_a[22:0];
   assign w_fb       = r_b[22:0];
   assign w_a_inf    = (w_ea == 8'hFF) && (w_fa == 23'd0);
   assign w_b_inf    = (w_eb == 8'hFF) && (w_fb == 23'd0);
   // NaN in, or inf - inf with equal raw signs (same-sign infinities cancel)
   assign w_nan      = ((w_ea == 8'hFF) && (w_fa != 23'd0)) ||
                       ((w_eb == 8'hFF) && (w_fb != 23'd0)) ||
                       (w_a_inf && w_b_inf && (r_a[31] == r_b[31]));
   assign w_special  = (w_ea == 8'hFF) || (w_eb == 8'hFF);
   // Infinite result takes A's sign if A is infinite, else the negated B sign
   assign w_inf_sign = w_a_inf ? r_a[31] : ~r_b[31];

   // Magnitude ordering: exponent first, then mantissa
   assign w_swap     = {r_ey, r_my} > {r_ex, r_mx};
   assign w_diff     = r_ex - r_ey;
   // Never negative in the subtract case because X holds the larger magnitude
   assign w_sum      = (r_sx == r_sy) ? (r_mx + r_my) : (r_mx - r_my);

   assign Result   = r_result;
   assign Done     = r_done;
   assign ovf_flag = r_ovf;
   assign unf_flag = r_unf;
   assign state    = SW'(r_state);
   assign nstate   = SW'(w_nstate);

   // Next-state decode; unknown codes fall back to IDLE
   always_comb begin
      w_nstate = ST_IDLE;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_nstate = ST_UNPACK;
            end else begin
               w_nstate = ST_IDLE;
            end
         end
         ST_UNPACK: begin
            if (w_special) begin
               w_nstate = ST_PACK;
            end else begin
               w_nstate = ST_SWAP;
            end
         end
         ST_SWAP: begin
            w_nstate = ST_ALIGN;
         end
         ST_ALIGN: begin
            if (w_diff == 10'd0) begin
               w_nstate = ST_ADDSUB;
            end else if (w_diff >= 10'd25) begin
               w_nstate = ST_ADDSUB;
            end else begin
               w_nstate = ST_ALIGN;
            end
         end
         ST_ADDSUB: begin
            if (w_sum == 25'd0) begin
               w_nstate = ST_PACK;
            end else begin
               w_nstate = ST_NORM;
            end
         end
         ST_NORM: begin
            if (r_mx[24]) begin
               w_nstate = ST_PACK;
            end else if (r_mx[23]) begin
               w_nstate = ST_PACK;
            end else if (r_ex <= 10'd1) begin
               w_nstate = ST_PACK;
            end else begin
               w_nstate = ST_NORM;
            end
         end
         ST_PACK: begin
            w_nstate = ST_DONE;
         end
         ST_DONE: begin
            w_nstate = ST_IDLE;
         end
         default: begin
            w_nstate = ST_IDLE;
         end
      endcase
   end

   // State register plus the per-state datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_sx     <= 1'b0;
         r_sy     <= 1'b0;
         r_ex     <= 10'd0;
         r_ey     <= 10'd0;
         r_mx     <= 25'd0;
         r_my     <= 25'd0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_done  <= (w_nstate == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a   <= A;
                  r_b   <= B;
                  r_ovf <= 1'b0;
                  r_unf <= 1'b0;
               end
            end
            ST_UNPACK: begin
               if (w_special) begin
                  // Encode the special result directly into the X fields
                  r_ex <= 10'd255;
                  if (w_nan) begin
                     r_sx <= 1'b0;
                     r_mx <= {2'b00, 23'h400000};
                  end else begin
                     r_sx  <= w_inf_sign;
                     r_mx  <= 25'd0;
                     r_ovf <= 1'b1;
                  end
               end else begin
                  r_sx <= r_a[31];
                  r_ex <= {2'b00, w_ea};
                  r_mx <= (w_ea == 8'd0) ? 25'd0 : {2'b01, w_fa};
                  r_sy <= ~r_b[31];
                  r_ey <= {2'b00, w_eb};
                  r_my <= (w_eb == 8'd0) ? 25'd0 : {2'b01, w_fb};
               end
            end
            ST_SWAP: begin
               if (w_swap) begin
                  r_sx <= r_sy;
                  r_ex <= r_ey;
                  r_mx <= r_my;
                  r_sy <= r_sx;
                  r_ey <= r_ex;
                  r_my <= r_mx;
               end
            end
            ST_ALIGN: begin
               if (w_diff == 10'd0) begin
                  r_my <= r_my;
               end else if (w_diff >= 10'd25) begin
                  r_my <= 25'd0;
                  r_ey <= r_ex;
               end else begin
                  r_my <= r_my >> 1;
                  r_ey <= r_ey + 10'd1;
               end
            end
            ST_ADDSUB: begin
               if (w_sum == 25'd0) begin
                  // Exact cancellation always yields +0
                  r_sx <= 1'b0;
                  r_ex <= 10'd0;
                  r_mx <= 25'd0;
               end else begin
                  r_mx <= w_sum;
               end
            end
            ST_NORM: begin
               if (r_mx[24]) begin
                  if (r_ex >= 10'd254) begin
                     r_ex  <= 10'd255;
                     r_mx  <= 25'd0;
                     r_ovf <= 1'b1;
                  end else begin
                     r_mx <= r_mx >> 1;
                     r_ex <= r_ex + 10'd1;
                  end
               end else if (r_mx[23]) begin
                  r_mx <= r_mx;
               end else if (r_ex <= 10'd1) begin
                  // Would go denormal: flush to signed zero
                  r_ex  <= 10'd0;
                  r_mx  <= 25'd0;
                  r_unf <= 1'b1;
               end else begin
                  r_mx <= r_mx << 1;
                  r_ex <= r_ex - 10'd1;
               end
            end
            ST_PACK: begin
               r_result <= {r_sx, r_ex[7:0], r_mx[22:0]};
            end
            ST_DONE: begin
               r_result <= r_result;
            end
            default: begin
               r_result <= r_result;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_sub_sp_seq.sv
// Self-checking bench for fp_sub_sp_seq: directed cases plus randomized
// operands, scored by a queue-based monitor against an arithmetic model.
module tb_fp_sub_sp_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic [31:0] Result;
   logic        Done;
   logic        ovf_flag;
   logic        unf_flag;
   logic [3:0]  state;
   logic [3:0]  nstate;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        o;
      logic        u;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   done_cnt = 0;
   int   n_acc = 0;

   fp_sub_sp_seq #(.W(32), .SW(4)) dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
      .Result(Result), .Done(Done), .ovf_flag(ovf_flag), .unf_flag(unf_flag),
      .state(state), .nstate(nstate)
   );

   always #5 clk = ~clk;

   // Reference: real-valued style subtraction with truncation and flush-to-zero
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      int     ea, eb, ex, ey, d, ee;
      longint ma, mb, mx, my, m;
      logic   sa, sb, sx, sy;
      logic [30:0] qa, qb;
      e.a = a; e.b = b; e.r = 32'd0; e.o = 1'b0; e.u = 1'b0;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      sa = a[31];
      sb = ~b[31];
      if (ea == 255 || eb == 255) begin
         if ((ea == 255 && a[22:0] != 23'd0) || (eb == 255 && b[22:0] != 23'd0) ||
             (ea == 255 && eb == 255 && a[31] == b[31])) begin
            e.r = 32'h7FC00000;
         end else begin
            e.r = {((ea == 255) ? sa : sb), 31'h7F800000};
            e.o = 1'b1;
         end
         return e;
      end
      ma = (ea == 0) ? 64'd0 : (longint'(a[22:0]) + 64'h800000);
      mb = (eb == 0) ? 64'd0 : (longint'(b[22:0]) + 64'h800000);
      qa = (ea == 0) ? 31'd0 : a[30:0];
      qb = (eb == 0) ? 31'd0 : b[30:0];
      if (qa >= qb) begin
         sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
      end else begin
         sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
      end
      d = ex - ey;
      my = (d >= 25) ? 64'd0 : (my >> d);
      m = (sx == sy) ? (mx + my) : (mx - my);
      if (m == 0) begin
         e.r = 32'd0;
         return e;
      end
      ee = ex;
      if (m >= 64'h1000000) begin
         m = m >> 1;
         ee = ee + 1;
      end else begin
         while (m < 64'h800000) begin
            m = m << 1;
            ee = ee - 1;
         end
      end
      if (ee >= 255) begin
         e.r = {sx, 31'h7F800000};
         e.o = 1'b1;
      end else if (ee < 1) begin
         e.r = {sx, 31'd0};
         e.u = 1'b1;
      end else begin
         e.r = {sx, 8'(ee), m[22:0]};
      end
      return e;
   endfunction

   // Monitor: every Done pulse pops one expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && Done) begin
            done_cnt++;
            n_chk++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_done Result=%h", Result);
            end else begin
               e = q.pop_front();
               if (Result !== e.r || ovf_flag !== e.o || unf_flag !== e.u) begin
                  n_err++;
                  $display("FAIL result A=%h B=%h got %h ovf=%b unf=%b expected %h ovf=%b unf=%b",
                           e.a, e.b, Result, ovf_flag, unf_flag, e.r, e.o, e.u);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      n_chk++;
      if (got !== exp_v) begin
         n_err++;
         $display("FAIL %s got %h expected %h", name, got, exp_v);
      end
   endtask

   // Pulse start for one cycle; returns #1 after the sampling edge
   task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!Done && lat < 200);
      if (!Done) begin
         n_chk++;
         n_err++;
         $display("FAIL timeout waiting for Done after %0d cycles", lat);
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int exp_lat);
      int lat;
      q.push_back(model(a, b));
      n_acc++;
      pulse_start(a, b);
      wait_done(lat);
      if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      int d0;
      int mode, ea, eb, dd;
      logic [31:0] a, b;

      // Reset state
      #2;
      check("rst_state", 32'(state), 32'd0);
      check("rst_nstate", 32'(nstate), 32'd0);
      check("rst_result", Result, 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_flags", {30'd0, ovf_flag, unf_flag}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Directed cases
      run_op(32'h40400000, 32'h3F800000, 7);
      run_op(32'h3F800000, 32'h40400000, 7);
      run_op(32'h3F800000, 32'h3F800000, 0);
      run_op(32'h3FC00000, 32'h3FA00000, 8);
      run_op(32'h7F7FFFFF, 32'hFF7FFFFF, 6);
      run_op(32'h7F800000, 32'h7F800000, 0);

      // Reset mid-ALIGN aborts without a Done
      pulse_start(32'h40400000, 32'h3C000000);
      for (int i = 0; i < 10 && state != 4'd3; i++) begin
         @(posedge clk);
         #1;
      end
      check("align_reached", 32'(state), 32'd3);
      d0 = done_cnt;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_state", 32'(state), 32'd0);
      check("abort_result", Result, 32'd0);
      check("abort_done", 32'(Done), 32'd0);
      check("abort_flags", {30'd0, ovf_flag, unf_flag}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_cnt), 32'(d0));
      run_op(32'h40400000, 32'h3C000000, 0);

      // start while busy and during DONE is ignored
      q.push_back(model(32'h4B000000, 32'h3F800000));
      n_acc++;
      pulse_start(32'h4B000000, 32'h3F800000);
      repeat (3) @(negedge clk);
      A = 32'h40000000; B = 32'h3F000000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      A = 32'h41000000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      A = 32'h42000000; B = 32'h3F800000; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("start_in_done_ignored", 32'(state), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      check("one_done_per_start", 32'(done_cnt), 32'(n_acc));

      // Randomized operands
      for (int n = 0; n < 300; n++) begin
         mode = $urandom_range(0, 9);
         a = $urandom;
         b = $urandom;
         case (mode)
            0: begin end
            1: begin
               if ($urandom_range(0, 1) == 1) begin
                  a[30:23] = 8'hFF;
                  if ($urandom_range(0, 1) == 1) a[22:0] = 23'd0;
               end else begin
                  b[30:23] = 8'hFF;
                  if ($urandom_range(0, 1) == 1) b[22:0] = 23'd0;
               end
               if ($urandom_range(0, 3) == 0) begin
                  a[30:23] = 8'hFF; a[22:0] = 23'd0;
                  b[30:23] = 8'hFF; b[22:0] = 23'd0;
               end
            end
            2: begin
               a[30:23] = 8'($urandom_range(1, 254));
               b[30:23] = 8'd0;
               if ($urandom_range(0, 1) == 1) b[22:0] = 23'd0;
            end
            3: begin
               a[30:23] = 8'($urandom_range(1, 254));
               b = a;
               b[7:0] = 8'($urandom);
               b[31] = 1'($urandom);
            end
            8: begin
               a[30:23] = 8'd254;
               b[30:23] = 8'd254;
               b[31] = ~a[31];
            end
            9: begin
               a[30:23] = 8'($urandom_range(1, 3));
               b[30:23] = 8'($urandom_range(1, 3));
               b[31] = a[31];
            end
            default: begin
               ea = $urandom_range(1, 254);
               dd = $urandom_range(0, 30);
               eb = ($urandom_range(0, 1) == 1) ? (ea + dd) : (ea - dd);
               if (eb < 1) eb = 1;
               if (eb > 254) eb = 254;
               a[30:23] = 8'(ea);
               b[30:23] = 8'(eb);
            end
         endcase
         run_op(a, b, 0);
      end

      // Drain and final accounting
      for (int i = 0; i < 200 && q.size() != 0; i++) begin
         @(posedge clk);
      end
      check("queue_drained", 32'(q.size()), 32'd0);
      check("done_count", 32'(done_cnt), 32'(n_acc));
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fp_sub_sp_seq.md
Name: fp_sub_sp_seq

Overview:
- Multi-cycle, FSM-driven IEEE-754 single-precision subtractor. Computes Result = A − B.
- Companion to the team's sequential single-precision adder. Same operand/result/flag style, plus an explicit start/done handshake.
- Sits in the VLSI arithmetic lab datapath and exposes state/nstate for debug and waveform checking.

Parameters:
- W, 32, operand/result width. Only 32 is supported.
- SW, 4, width of the state/nstate debug outputs.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request. Sampled only in IDLE.
- A  input  W  minuend, IEEE-754 single.
- B  input  W  subtrahend, IEEE-754 single.
- Result  output  W  A − B, held until the next accepted start.
- Done  output  1  one-cycle pulse when Result is valid.
- ovf_flag  output  1  exponent overflow on the last operation. Held with Result.
- unf_flag  output  1  result underflowed/flushed to zero. Held with Result.
- state  output  SW  current FSM state.
- nstate  output  SW  next FSM state (combinational).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - Result, Done, ovf_flag and unf_flag are all 0.
  - All internal registers are cleared.
  - A reset during any state aborts the operation. No Done is issued.
- State encodings: IDLE=0, UNPACK=1, SWAP=2, ALIGN=3, ADDSUB=4, NORM=5, PACK=6, DONE=7. Codes 8–15 go to IDLE.
- IDLE:
  - On start=1, register A and B, clear ovf_flag/unf_flag, go to UNPACK.
  - start in any other state is ignored.
- UNPACK:
  - Split sign, exponent and 23-bit fraction.
  - Effective subtrahend sign = ~B[31].
  - Exponent 0 is treated as zero; denormals are flushed to zero.
  - Either exponent = 255 goes straight to PACK with special-case results:
    - NaN in either operand gives 0x7FC00000.
    - inf − inf of the same sign gives 0x7FC00000.
    - Otherwise the result is the infinity with the correct sign, and ovf_flag=1.
- SWAP: order operands so the larger magnitude (exponent, then mantissa) is operand X. Result sign = sign of X.
- ALIGN:
  - Right-shift Y's 24-bit mantissa (hidden bit included) by 1 per cycle and increment its exponent, until the exponents are equal.
  - If the exponent difference is ≥ 25, zero Y in one cycle.
  - Shifted-out bits are discarded (truncation).
- ADDSUB:
  - Signs equal after negation: 25-bit add.
  - Signs differ: X − Y. This is never negative because of SWAP.
  - A zero magnitude sets Result=+0 and goes to PACK.
- NORM:
  - Carry out (bit 24): shift right 1, exponent+1, one cycle.
  - Otherwise shift left 1 and decrement the exponent per cycle until bit 23 = 1.
  - If the exponent would drop below 1: Result = signed zero, unf_flag=1.
  - If the exponent reaches 255: Result = ±inf (0x7F800000 | sign), ovf_flag=1.
- PACK: assemble {sign, exp[7:0], mant[22:0]} into Result. Rounding is truncate toward zero.
- DONE: Done=1 for exactly one cycle, then IDLE. Result and flags hold until the next accepted start.
- Latency:
  - 6 cycles minimum from start to Done for equal exponents with no left normalisation.
  - Add 1 cycle per ALIGN shift and 1 cycle per NORM shift.
  - Maximum is bounded by 6 + 24 + 24.
- A start arriving in the same cycle that DONE returns to IDLE is not accepted. The earliest accepted start is the cycle after Done.

Test Plan:
- Reset held low mid-ALIGN (A=0x40400000, B=0x3C000000), then released → state=0, Result=0, Done never pulses; next start completes normally.
- A=0x40400000 (3.0), B=0x3F800000 (1.0) → Result=0x40000000, Done pulse after exactly 7 cycles (one ALIGN shift), flags 0.
- A=0x3F800000, B=0x40400000 → Result=0xC0000000 (−2.0).
- A=B=0x3F800000 → Result=0x00000000, unf_flag=0.
- A=0x3FC00000 (1.5), B=0x3FA00000 (1.25) → Result=0x3E800000 (0.25), with 2 NORM left-shift cycles observed on state.
- A=0x7F7FFFFF, B=0xFF7FFFFF → Result=0x7F800000, ovf_flag=1.
- A=0x7F800000, B=0x7F800000 → Result=0x7FC00000.
- start pulsed while busy → ignored; exactly one Done per accepted start.
